// File: rtl/mips32_pkg.sv
// mips32_pkg: boot loader state encoding and header field layout shared across the core slice
package mips32_pkg;
    typedef enum logic [2:0] {S_HDR, S_DATA, S_START, S_DONE, S_ERR} boot_state_t;
    localparam int HDR_CNT_LSB = 16;
    localparam int HDR_BASE_W  = 16;
endpackage

// File: rtl/mips32_boot_loader_if.sv
// mips32_boot_loader_if: host word stream (s_valid/s_data/s_ready) plus memory write port (mem_we/mem_addr/mem_wdata)
interface mips32_boot_loader_if #(parameter int ADDR_W = 10, parameter int DATA_W = 32);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    modport master (output s_valid, s_data, input s_ready, mem_we, mem_addr, mem_wdata);
    modport slave (input s_valid, s_data, output s_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/mips32_boot_loader.sv
// mips32_boot_loader: streams header/payload words from bus into memory with core halted, then loads core_pc and releases core_halt; reload restarts from DONE/ERR, err flags a bad base, words_written counts payload writes
module mips32_boot_loader
    import mips32_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk1,
    input  logic                  rst,
    mips32_boot_loader_if.slave   bus,
    input  logic                  reload,
    output logic                  core_halt,
    output logic                  core_pc_load,
    output logic [ADDR_W-1:0]     core_pc,
    output logic                  err,
    output logic [ADDR_W:0]       words_written
);
    boot_state_t state, nxt;
    logic [DATA_W-1:0] word;
    logic [HDR_BASE_W-1:0] base;
    logic [CNT_W-1:0] cnt, rem;
    logic [ADDR_W-1:0] addr;
    logic acc, legal, hdr_acc, dat_acc, restart;
    assign word    = bus.s_data;
    assign base    = word[HDR_BASE_W-1:0];
    assign cnt     = word[HDR_CNT_LSB +: CNT_W];
    assign legal   = (base >> ADDR_W) == '0;
    assign acc     = bus.s_valid && bus.s_ready;
    assign hdr_acc = acc && state == S_HDR;
    assign dat_acc = acc && state == S_DATA;
    assign restart = reload && (state == S_DONE || state == S_ERR);
    always_comb begin
        nxt = state;
        case (state)
            S_HDR:   if (acc) nxt = !legal ? S_ERR : cnt == '0 ? S_START : S_DATA;
            S_DATA:  if (acc && rem == CNT_W'(1)) nxt = S_HDR;
            S_START: nxt = S_DONE;
            default: if (reload) nxt = S_HDR;
        endcase
    end
    always_ff @(posedge clk1) begin
        if (rst) begin
            state         <= S_HDR;
            addr          <= '0;
            rem           <= '0;
            bus.s_ready   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            core_halt     <= 1'b1;
            core_pc_load  <= 1'b0;
            core_pc       <= '0;
            err           <= 1'b0;
            words_written <= '0;
        end else begin
            state        <= nxt;
            bus.s_ready  <= nxt == S_HDR || nxt == S_DATA;
            bus.mem_we   <= dat_acc;
            core_halt    <= nxt != S_DONE;
            core_pc_load <= nxt == S_START;
            err          <= nxt == S_ERR;
            if (hdr_acc && legal) begin
                addr <= ADDR_W'(base);
                rem  <= cnt;
                if (cnt == '0) core_pc <= ADDR_W'(base);
            end
            if (dat_acc) begin
                bus.mem_addr  <= addr;
                bus.mem_wdata <= word;
                addr          <= addr + 1'b1;
                rem           <= rem - 1'b1;
                if (!words_written[ADDR_W]) words_written <= words_written + 1'b1;
            end
            if (restart) words_written <= '0;
        end
    end
endmodule

// File: tb/tb_mips32_boot_loader.sv
// tb_mips32_boot_loader: directed load scenarios checked with immediate assertions against hand-computed values
module tb_mips32_boot_loader;
    logic clk1 = 1'b0;
    logic rst = 1'b1;
    logic reload = 1'b0;
    logic core_halt, core_pc_load, err;
    logic [9:0] core_pc;
    logic [10:0] words_written;
    int vectors = 0;
    int miscompares = 0;
    logic [9:0] wa[$];
    logic [31:0] wd[$];

    mips32_boot_loader_if #(.ADDR_W(10), .DATA_W(32)) bus();

    mips32_boot_loader #(.ADDR_W(10), .DATA_W(32), .CNT_W(16)) dut (
        .clk1(clk1), .rst(rst), .bus(bus), .reload(reload),
        .core_halt(core_halt), .core_pc_load(core_pc_load), .core_pc(core_pc),
        .err(err), .words_written(words_written)
    );

    always #5 clk1 = ~clk1;

    always @(negedge clk1) if (bus.mem_we === 1'b1) begin
        wa.push_back(bus.mem_addr);
        wd.push_back(bus.mem_wdata);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [9:0] a, input logic [31:0] d);
        if (i < wa.size()) begin
            chk({tag, "_addr"}, 64'(wa[i]), 64'(a));
            chk({tag, "_data"}, 64'(wd[i]), 64'(d));
        end else chk({tag, "_missing"}, 64'(wa.size()), 64'(i + 1));
    endtask

    task automatic send(input logic [31:0] w);
        int g = 0;
        @(negedge clk1);
        bus.s_valid = 1'b1;
        bus.s_data = w;
        while (bus.s_ready !== 1'b1 && g < 50) begin
            @(negedge clk1);
            g++;
        end
        if (g >= 50) chk("send_timeout", 64'(g), 64'(0));
        @(posedge clk1);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    task automatic pulse_reload;
        @(negedge clk1);
        reload = 1'b1;
        @(posedge clk1);
        #1 reload = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'(1));
        chk({tag, "_halt"}, 64'(core_halt), 64'(1));
        chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'(0));
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
        chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
        chk({tag, "_pc_load"}, 64'(core_pc_load), 64'(0));
        chk({tag, "_pc"}, 64'(core_pc), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
        chk({tag, "_ww"}, 64'(words_written), 64'(0));
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        idle(2);
        chk_reset_vals("reset");
        @(negedge clk1) rst = 1'b0;

        // program load
        wa.delete(); wd.delete();
        send(32'h0003_0000);
        send(32'h2019_0200);
        send(32'h2018_0300);
        send(32'h0319_1020);
        send(32'h0000_0000);
        chk("prog_pc_load", 64'(core_pc_load), 64'(1));
        chk("prog_pc", 64'(core_pc), 64'(0));
        chk("prog_halt_held", 64'(core_halt), 64'(1));
        idle(1);
        chk("prog_pc_load_off", 64'(core_pc_load), 64'(0));
        chk("prog_halt_released", 64'(core_halt), 64'(0));
        chk("prog_s_ready_done", 64'(bus.s_ready), 64'(0));
        chk("prog_ww", 64'(words_written), 64'(3));
        chk("prog_nwr", 64'(wa.size()), 64'(3));
        chk_wr("prog_w0", 0, 10'h000, 32'h2019_0200);
        chk_wr("prog_w1", 1, 10'h001, 32'h2018_0300);
        chk_wr("prog_w2", 2, 10'h002, 32'h0319_1020);

        // reload from DONE
        pulse_reload();
        chk("reload_halt", 64'(core_halt), 64'(1));
        chk("reload_ww", 64'(words_written), 64'(0));
        chk("reload_s_ready", 64'(bus.s_ready), 64'(1));

        // multi-segment
        wa.delete(); wd.delete();
        send(32'h0002_0023); send(32'd1); send(32'd11);
        send(32'h0002_0043); send(32'd22); send(32'd33);
        send(32'h0000_0005);
        chk("multi_pc_load", 64'(core_pc_load), 64'(1));
        chk("multi_pc", 64'(core_pc), 64'(5));
        idle(1);
        chk("multi_ww", 64'(words_written), 64'(4));
        chk("multi_nwr", 64'(wa.size()), 64'(4));
        chk_wr("multi_w0", 0, 10'h023, 32'd1);
        chk_wr("multi_w1", 1, 10'h024, 32'd11);
        chk_wr("multi_w2", 2, 10'h043, 32'd22);
        chk_wr("multi_w3", 3, 10'h044, 32'd33);
        pulse_reload();

        // address wrap
        wa.delete(); wd.delete();
        send(32'h0002_03FF); send(32'hA); send(32'hB);
        idle(2);
        chk("wrap_nwr", 64'(wa.size()), 64'(2));
        chk_wr("wrap_w0", 0, 10'h3FF, 32'hA);
        chk_wr("wrap_w1", 1, 10'h000, 32'hB);
        chk("wrap_err", 64'(err), 64'(0));
        chk("wrap_ww", 64'(words_written), 64'(2));

        // bad base
        wa.delete(); wd.delete();
        send(32'h0001_0400);
        chk("bad_err", 64'(err), 64'(1));
        chk("bad_s_ready", 64'(bus.s_ready), 64'(0));
        chk("bad_halt", 64'(core_halt), 64'(1));
        idle(3);
        chk("bad_err_sticky", 64'(err), 64'(1));
        chk("bad_nwr", 64'(wa.size()), 64'(0));
        pulse_reload();
        chk("bad_reload_err", 64'(err), 64'(0));
        chk("bad_reload_s_ready", 64'(bus.s_ready), 64'(1));
        chk("bad_reload_ww", 64'(words_written), 64'(0));

        // gaps during a 16-word segment
        wa.delete(); wd.delete();
        send(32'h0010_0100);
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, 2));
            send(32'h1000 + i);
        end
        idle(3);
        chk("gap_nwr", 64'(wa.size()), 64'(16));
        for (int i = 0; i < 16; i++) chk_wr($sformatf("gap_w%0d", i), i, 10'h100 + 10'(i), 32'h1000 + i);
        chk("gap_ww", 64'(words_written), 64'(16));
        chk("gap_back_in_hdr", 64'(bus.s_ready), 64'(1));

        // reset mid-DATA, rst colliding with reload
        wa.delete(); wd.delete();
        send(32'h0004_0200); send(32'h55); send(32'h66);
        @(negedge clk1);
        rst = 1'b1;
        reload = 1'b1;
        @(posedge clk1);
        #1;
        chk_reset_vals("mid_rst");
        @(negedge clk1);
        rst = 1'b0;
        reload = 1'b0;
        chk("mid_rst_nwr", 64'(wa.size()), 64'(2));
        wa.delete(); wd.delete();
        send(32'h0001_0010); send(32'h77); send(32'h0000_0010);
        chk("fresh_pc_load", 64'(core_pc_load), 64'(1));
        chk("fresh_pc", 64'(core_pc), 64'(10'h010));
        idle(1);
        chk("fresh_halt", 64'(core_halt), 64'(0));
        chk("fresh_ww", 64'(words_written), 64'(1));
        chk("fresh_nwr", 64'(wa.size()), 64'(1));
        chk_wr("fresh_w0", 0, 10'h010, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
